// File: rtl/cop_hash_pkg.sv
// rtl/cop_hash_pkg.sv - shared types, constants and cop_op field positions for the hash bridge
package cop_hash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FOLD_AB  = 2'd0,
        FOLD_CD  = 2'd1,
        FOLD_XOR = 2'd2,
        FOLD_ADD = 2'd3
    } fold_mode_t;

    localparam logic [127:0] MD5_IV = 128'h67452301_EFCDAB89_98BADCFE_10325476;

    localparam int OP_OPC_LSB  = 0;
    localparam int OP_OPC_MSB  = 7;
    localparam int OP_MODE_LSB = 8;
    localparam int OP_MODE_MSB = 9;
    localparam int OP_LANE_LSB = 10;
    localparam int OP_LANE_MSB = 11;
    localparam int OP_IVSEL    = 12;

endpackage

// File: rtl/cop_hash_bridge_if.sv
// rtl/cop_hash_bridge_if.sv - coprocessor command/result port between the CPU and the hash bridge
interface cop_hash_bridge_if;

    logic         cop_go;
    logic [23:0]  cop_op;
    logic [127:0] cop_out;
    logic         cop_done;
    logic [63:0]  cop_in;
    logic         busy;
    logic [1:0]   err;

    modport master (
        output cop_go, cop_op, cop_out,
        input  cop_done, cop_in, busy, err
    );

    modport slave (
        input  cop_go, cop_op, cop_out,
        output cop_done, cop_in, busy, err
    );

endinterface

// File: rtl/cop_hash_fold.sv
// rtl/cop_hash_fold.sv - combinational 128-to-64 digest fold selected by fold mode
module cop_hash_fold
    import cop_hash_pkg::*;
(
    input  fold_mode_t   mode,
    input  logic [127:0] dig,
    output logic [63:0]  res
);

    logic [31:0] a, b, c, d;

    assign a = dig[127:96];
    assign b = dig[95:64];
    assign c = dig[63:32];
    assign d = dig[31:0];

    always_comb begin
        res = '0;
        case (mode)
            FOLD_AB:  res = {a, b};
            FOLD_CD:  res = {c, d};
            FOLD_XOR: res = {a ^ c, b ^ d};
            FOLD_ADD: res = {a + c, b + d};
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/cop_hash_bridge.sv
// rtl/cop_hash_bridge.sv - m32632 coprocessor bridge to LANES fixed-latency hash cores; COP_HASH_PERF_EN adds a completion counter
module cop_hash_bridge
    import cop_hash_pkg::*;
#(
    parameter int          LANES    = 2,
    parameter int          PIPE_LAT = 64,
    parameter logic [7:0]  OPCODE   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    cop_hash_bridge_if.slave       cop,
    output logic [LANES*512-1:0]   core_wb,
    output logic [LANES*128-1:0]   core_iv,
    input  logic [LANES*128-1:0]   core_dig
);

    localparam int          CW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [2:0]  LANES_W = 3'(LANES);

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  lane_q;
    fold_mode_t  mode_q;

    logic [7:0]  opc_req;
    logic [1:0]  lane_req;
    logic        ivsel_req;
    logic        legal_hash;
    logic        unused_op_bits;

    logic [127:0] dig_sel;
    logic [63:0]  fold_res;

    assign opc_req        = cop.cop_op[OP_OPC_MSB:OP_OPC_LSB];
    assign lane_req       = cop.cop_op[OP_LANE_MSB:OP_LANE_LSB];
    assign ivsel_req      = cop.cop_op[OP_IVSEL];
    assign unused_op_bits = ^cop.cop_op[23:13];

    // Lane bound is compared at 3 bits so LANES=4 accepts every 2-bit lane value.
    assign legal_hash = (opc_req == OPCODE) && ({1'b0, lane_req} < LANES_W);

`ifdef COP_HASH_PERF_EN
    logic [31:0] perf_cnt;
    logic        perf_req;
    assign perf_req = (opc_req == 8'(OPCODE + 8'd1));
`endif

    always_comb begin
        dig_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == 2'(i)) dig_sel = core_dig[i*128 +: 128];
        end
    end

    cop_hash_fold u_fold (
        .mode (mode_q),
        .dig  (dig_sel),
        .res  (fold_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lane_q       <= '0;
            mode_q       <= FOLD_AB;
            cop.cop_done <= 1'b0;
            cop.cop_in   <= '0;
            cop.busy     <= 1'b0;
            cop.err      <= '0;
            core_wb      <= '0;
            core_iv      <= '0;
`ifdef COP_HASH_PERF_EN
            perf_cnt     <= '0;
`endif
        end else begin
            // A strobe outside IDLE is dropped; the in-flight command is untouched.
            if (cop.cop_go && (state != IDLE)) cop.err[1] <= 1'b1;

            case (state)
                IDLE: begin
                    cop.cop_done <= 1'b0;
                    if (cop.cop_go) begin
                        cop.busy <= 1'b1;
                        if (legal_hash) begin
                            lane_q <= lane_req;
                            mode_q <= fold_mode_t'(cop.cop_op[OP_MODE_MSB:OP_MODE_LSB]);
                            for (int i = 0; i < LANES; i++) begin
                                if (lane_req == 2'(i)) begin
                                    core_wb[i*512 +: 512] <= {4{cop.cop_out}};
                                    core_iv[i*128 +: 128] <= ivsel_req ? cop.cop_out : MD5_IV;
                                end
                            end
                            state <= ISSUE;
                        end
`ifdef COP_HASH_PERF_EN
                        else if (perf_req) begin
                            cop.cop_in   <= {32'h0, perf_cnt};
                            cop.cop_done <= 1'b1;
                            state        <= DONE;
                        end
`endif
                        else begin
                            cop.err[0]   <= 1'b1;
                            cop.cop_in   <= '1;
                            cop.cop_done <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end

                ISSUE: begin
                    cnt   <= CW'(PIPE_LAT - 1);
                    state <= WAIT;
                end

                WAIT: begin
                    if (cnt == '0) begin
                        cop.cop_in   <= fold_res;
                        cop.cop_done <= 1'b1;
                        state        <= DONE;
`ifdef COP_HASH_PERF_EN
                        if (perf_cnt != 32'hFFFF_FFFF) perf_cnt <= perf_cnt + 32'd1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    cop.cop_done <= 1'b0;
                    cop.busy     <= 1'b0;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cop_hash_bridge.sv
// tb/tb_cop_hash_bridge.sv - directed self-checking bench for cop_hash_bridge with a 4-cycle stub core
module tb_cop_hash_bridge;

    localparam int LANES    = 2;
    localparam int PIPE_LAT = 4;
    localparam logic [127:0] STD_IV = 128'h67452301_EFCDAB89_98BADCFE_10325476;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [LANES*512-1:0] core_wb;
    logic [LANES*128-1:0] core_iv;
    logic [LANES*128-1:0] core_dig;

    int total = 0;
    int bad   = 0;

    cop_hash_bridge_if bus ();

    cop_hash_bridge #(.LANES(LANES), .PIPE_LAT(PIPE_LAT), .OPCODE(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .cop      (bus.slave),
        .core_wb  (core_wb),
        .core_iv  (core_iv),
        .core_dig (core_dig)
    );

    always #5 clk = ~clk;

    // Stub core: digest = iv + wb[127:0] per 32-bit word, four register stages later.
    logic [127:0] pipe [LANES][4];

    function automatic logic [127:0] stub_sum(input logic [127:0] iv, input logic [127:0] w);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = iv[k*32 +: 32] + w[k*32 +: 32];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            pipe[l][0] <= stub_sum(core_iv[l*128 +: 128], core_wb[l*512 +: 128]);
            for (int s = 1; s < 4; s++) pipe[l][s] <= pipe[l][s-1];
        end
    end

    always_comb begin
        core_dig = '0;
        for (int l = 0; l < LANES; l++) core_dig[l*128 +: 128] = pipe[l][3];
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command, waits for cop_done (bounded), checks latency, result, busy and pulse width.
    task automatic run_cmd(input string tag, input logic [23:0] op, input logic [127:0] data,
                           input int exp_lat, input logic [63:0] exp_res, input int ovr);
        int lat;
        logic [63:0] res;
        logic busy_ok;
        lat = -1;
        res = '0;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.cop_go  = 1'b1;
        bus.cop_op  = op;
        bus.cop_out = data;
        @(posedge clk); #1;
        for (int i = 1; i <= 20; i++) begin
            bus.cop_go = (i == ovr);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.cop_done === 1'b1) begin
                lat = i;
                res = bus.cop_in;
                break;
            end
            @(posedge clk); #1;
        end
        bus.cop_go = 1'b0;
        chk({tag, "_lat"}, 512'(lat), 512'(exp_lat));
        chk({tag, "_res"}, 512'(res), 512'(exp_res));
        if (exp_lat > 1) chk({tag, "_busy"}, 512'(busy_ok), 512'(1'b1));
        @(posedge clk); #1;
        chk({tag, "_done_low"}, 512'(bus.cop_done), 512'(1'b0));
        chk({tag, "_busy_low"}, 512'(bus.busy), 512'(1'b0));
        chk({tag, "_hold"}, 512'(bus.cop_in), 512'(exp_res));
    endtask

    initial begin
        int extra_done;
        bus.cop_go  = 1'b0;
        bus.cop_op  = '0;
        bus.cop_out = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 512'(bus.cop_done), 512'(1'b0));
        chk("rst_in",   512'(bus.cop_in),   512'(64'h0));
        chk("rst_busy", 512'(bus.busy),     512'(1'b0));
        chk("rst_err",  512'(bus.err),      512'(2'b00));
        chk("rst_wb",   512'(core_wb[1023:512]), 512'(0));
        chk("rst_iv",   512'(core_iv),      512'(256'h0));
        @(negedge clk);
        rst = 1'b0;

        run_cmd("t1_mode0", 24'h0000A5, 128'h0, 6, 64'h67452301_EFCDAB89, 0);
        chk("t1_err", 512'(bus.err), 512'(2'b00));
        chk("t1_iv0", 512'(core_iv[127:0]), 512'(STD_IV));

        run_cmd("t_mode1", 24'h0001A5, 128'h00000000_00000000_00000001_00000002,
                6, 64'h98BADCFF_10325478, 0);
        chk("m1_wb0", core_wb[511:0], {4{128'h00000000_00000000_00000001_00000002}});

        run_cmd("t_mode2", 24'h0006A5, 128'h00000001_00000000_00000000_00000000,
                6, 64'hFFFFFFFC_FFFFFFFF, 0);

        run_cmd("t5_mode3", 24'h0017A5, 128'h40000000_00000001_40000000_00000002,
                6, 64'h00000000_00000006, 0);
        chk("t5_iv1", 512'(core_iv[255:128]), 512'(128'h40000000_00000001_40000000_00000002));
        chk("t5_err", 512'(bus.err), 512'(2'b00));

        run_cmd("t2_illegal", 24'h00005A, 128'hDEAD, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("t2_err", 512'(bus.err), 512'(2'b01));
        chk("t2_wb0", core_wb[511:0], {4{128'h00000000_00000000_00000001_00000002}});
        chk("t2_iv0", 512'(core_iv[127:0]), 512'(STD_IV));

        run_cmd("t3_lane2", 24'h0008A5, 128'hBEEF, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("t3_err0", 512'(bus.err[0]), 512'(1'b1));
        chk("t3_wb1", core_wb[1023:512], {4{128'h40000000_00000001_40000000_00000002}});

        run_cmd("t4_overrun", 24'h0000A5, 128'h0, 6, 64'h67452301_EFCDAB89, 3);
        chk("t4_err", 512'(bus.err), 512'(2'b11));
        extra_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.cop_done === 1'b1) extra_done++;
        end
        chk("t4_no_2nd_done", 512'(extra_done), 512'(0));

        // Reset during WAIT: cop_go sampled at cycle 0, rst raised in cycle 3.
        @(negedge clk);
        bus.cop_go  = 1'b1;
        bus.cop_op  = 24'h0004A5;
        bus.cop_out = 128'h1234;
        @(posedge clk); #1;
        bus.cop_go = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_busy_pre", 512'(bus.busy), 512'(1'b1));
        rst = 1'b1;
        #1;
        chk("t6_busy",  512'(bus.busy),   512'(1'b0));
        chk("t6_in",    512'(bus.cop_in), 512'(64'h0));
        chk("t6_err",   512'(bus.err),    512'(2'b00));
        chk("t6_wb",    core_wb,          512'(0));
        chk("t6_iv",    512'(core_iv),    512'(256'h0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.cop_done === 1'b1) extra_done++;
        end
        chk("t6_no_done", 512'(extra_done), 512'(0));

        for (int n = 0; n < 3; n++)
            run_cmd("perf_pre", 24'h0000A5, 128'h0, 6, 64'h67452301_EFCDAB89, 0);
`ifdef COP_HASH_PERF_EN
        run_cmd("perf_read", 24'h0000A6, 128'h0, 1, 64'h3, 0);
        chk("perf_err", 512'(bus.err), 512'(2'b00));
`else
        run_cmd("perf_off", 24'h0000A6, 128'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("perf_off_err", 512'(bus.err), 512'(2'b01));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
